// File: rtl/map_pkg.sv
// Shared geometry, cell codes and FSM encodings for the tile-map write path.
package map_pkg;

  localparam int unsigned MAP_W     = 20;
  localparam int unsigned MAP_H     = 15;
  localparam int unsigned MAP_CELLS = MAP_W * MAP_H;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned CELL_W    = 3;

  typedef enum logic [CELL_W-1:0] {
    EMPTY  = 3'd0,
    BORDER = 3'd1,
    BRICK  = 3'd2,
    BASE1  = 3'd3,
    BASE2  = 3'd4
  } cell_t;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_BROKE = 2'd1,
    RES_BASE  = 2'd2,
    RES_SOLID = 2'd3
  } result_t;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RD   = 2'd2,
    ST_EVAL = 2'd3
  } state_t;

  typedef enum logic {
    PLAYER1 = 1'b0,
    PLAYER2 = 1'b1
  } player_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the last granted player loses the next tie.
module rr_arbiter2
  import map_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    req1,
  input  logic    req2,
  input  logic    take,
  output logic    gnt_valid,
  output player_t gnt_id
);

  player_t rr_last;

  // Player 1 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= PLAYER2;
    end else if (take && gnt_valid) begin
      rr_last <= gnt_id;
    end
  end

  always_comb begin
    gnt_valid = req1 | req2;
    gnt_id    = PLAYER1;
    if (req1 && req2) begin
      gnt_id = (rr_last == PLAYER1) ? PLAYER2 : PLAYER1;
    end else if (req2) begin
      gnt_id = PLAYER2;
    end
  end

endmodule

// File: rtl/map_arbiter.sv
// Sole writer of the tile map: ROM reload, then serialised read-modify-write of bullet hits.
module map_arbiter
  import map_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              req2,
  input  logic [ADDR_W-1:0] addr2,
  output logic              ack1,
  output logic              ack2,
  output logic [1:0]        result,
  input  logic              init_start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [CELL_W-1:0] rom_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [CELL_W-1:0] mem_wdata,
  input  logic [CELL_W-1:0] mem_rdata,
  output logic              busy,
  output logic              win1,
  output logic              win2
);

  localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(MAP_CELLS);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  player_t           id_q;
  logic              oob_q;
  logic              init_pending;

  logic              gnt_valid;
  player_t           gnt_id;
  logic              take;
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_oob;
  logic              set_win1;
  logic              set_win2;

  assign take     = (state == ST_IDLE) && !(init_start || init_pending);
  assign gnt_addr = (gnt_id == PLAYER2) ? addr2 : addr1;
  assign gnt_oob  = (gnt_addr >= CELLS_A);
  assign busy     = (state == ST_INIT);

  rr_arbiter2 u_rr (
    .clk       (Clk),
    .reset     (Reset),
    .req1      (req1),
    .req2      (req2),
    .take      (take),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Memory and ack decode; EVAL depends on the RAM word returned this cycle.
  always_comb begin
    rom_addr  = '0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    ack1      = 1'b0;
    ack2      = 1'b0;
    result    = RES_NONE;
    set_win1  = 1'b0;
    set_win2  = 1'b0;
    case (state)
      ST_INIT: begin
        if (cnt < CELLS_A) begin
          rom_addr = cnt;
        end
        if (cnt != '0) begin
          mem_we    = 1'b1;
          mem_addr  = cnt - ADDR_W'(1);
          mem_wdata = rom_data;
        end
      end
      ST_RD: begin
        mem_addr = addr_q;
      end
      ST_EVAL: begin
        ack1 = (id_q == PLAYER1);
        ack2 = (id_q == PLAYER2);
        if (oob_q) begin
          result = RES_SOLID;
        end else begin
          mem_addr = addr_q;
          // Once either side has won, the map is frozen until the next round.
          if (!(win1 || win2)) begin
            case (mem_rdata)
              BRICK: begin
                mem_we    = 1'b1;
                mem_wdata = EMPTY;
                result    = RES_BROKE;
              end
              BASE1: begin
                if (id_q == PLAYER2) begin
                  result   = RES_BASE;
                  set_win2 = 1'b1;
                end else begin
                  result = RES_SOLID;
                end
              end
              BASE2: begin
                if (id_q == PLAYER1) begin
                  result   = RES_BASE;
                  set_win1 = 1'b1;
                end else begin
                  result = RES_SOLID;
                end
              end
              BORDER:  result = RES_SOLID;
              default: result = RES_NONE;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  // Sequencer: INIT streams the ROM through, then IDLE -> RD -> EVAL per hit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= ST_INIT;
      cnt          <= '0;
      addr_q       <= '0;
      id_q         <= PLAYER1;
      oob_q        <= 1'b0;
      init_pending <= 1'b0;
      win1         <= 1'b0;
      win2         <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == CELLS_A) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (init_start || init_pending) begin
            state        <= ST_INIT;
            cnt          <= '0;
            init_pending <= 1'b0;
            win1         <= 1'b0;
            win2         <= 1'b0;
          end else if (gnt_valid) begin
            id_q   <= gnt_id;
            addr_q <= gnt_addr;
            oob_q  <= gnt_oob;
            state  <= gnt_oob ? ST_EVAL : ST_RD;
          end
        end
        ST_RD: begin
          if (init_start) begin
            init_pending <= 1'b1;
          end
          state <= ST_EVAL;
        end
        ST_EVAL: begin
          if (init_start) begin
            init_pending <= 1'b1;
          end
          if (set_win1) begin
            win1 <= 1'b1;
          end
          if (set_win2) begin
            win2 <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_map_arbiter.sv
// Bench for map_arbiter: ROM/RAM environment plus a rule-level map model.
module tb_map_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req1 = 1'b0, req2 = 1'b0;
  logic [8:0] addr1 = '0, addr2 = '0;
  logic       ack1, ack2;
  logic [1:0] result;
  logic       init_start = 1'b0;
  logic [8:0] rom_addr;
  logic [2:0] rom_data = '0;
  logic [8:0] mem_addr;
  logic       mem_we;
  logic [2:0] mem_wdata;
  logic [2:0] mem_rdata = '0;
  logic       busy, win1, win2;

  logic       poke_en = 1'b0;
  logic [8:0] poke_addr = '0;
  logic [2:0] poke_data = '0;
  logic [2:0] ram [0:299];

  int checks = 0;
  int failures = 0;

  int m_map [0:299];
  bit m_win1, m_win2;
  int m_last;

  map_arbiter dut (
    .Clk        (clk),
    .Reset      (reset),
    .req1       (req1),
    .addr1      (addr1),
    .req2       (req2),
    .addr2      (addr2),
    .ack1       (ack1),
    .ack2       (ack2),
    .result     (result),
    .init_start (init_start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .win1       (win1),
    .win2       (win2)
  );

  always #5 clk = ~clk;

  // Default-map ROM (cell k = k mod 5) and the map RAM, both 1-cycle read latency.
  always @(posedge clk) begin
    rom_data <= (rom_addr < 9'd300) ? 3'(int'(rom_addr) % 5) : 3'd0;
    if (poke_en) begin
      ram[poke_addr] <= poke_data;
    end else if (mem_addr < 9'd300) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end else begin
      mem_rdata <= 3'd0;
    end
  end

  function automatic int lat(input int a);
    return (a >= 300) ? 1 : 2;
  endfunction

  task automatic model_reset(input bit with_rr);
    for (int k = 0; k < 300; k++) m_map[k] = k % 5;
    m_win1 = 0;
    m_win2 = 0;
    if (with_rr) m_last = 2;
  endtask

  // Game rules for one hit by player p on cell a.
  task automatic predict(input int p, input int a, output int res, output bit wr);
    wr = 0;
    res = 0;
    if (a >= 300) res = 3;
    else if (m_win1 || m_win2) res = 0;
    else begin
      case (m_map[a])
        2: begin res = 1; wr = 1; m_map[a] = 0; end
        1: res = 3;
        3: if (p == 2) begin res = 2; m_win2 = 1; end else res = 3;
        4: if (p == 1) begin res = 2; m_win1 = 1; end else res = 3;
        default: res = 0;
      endcase
    end
  endtask

  task automatic poke(input int a, input logic [2:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = 9'(a); poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
    m_map[a] = int'(d);
  endtask

  task automatic reset_and_init();
    int n;
    @(negedge clk);
    reset = 1'b1; req1 = 1'b0; req2 = 1'b0; init_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (busy) begin failures++; $display("FAIL init_timeout busy=%b after %0d cycles", busy, n); end
    model_reset(1);
  endtask

  task automatic test_reset();
    int n, nw, bad;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mem_we !== 1'b0 || ack1 !== 1'b0 || ack2 !== 1'b0 || result !== 2'd0)
      begin failures++; $display("FAIL reset_outputs busy=%b we=%b ack=%b%b res=%0d exp 1 0 00 0", busy, mem_we, ack1, ack2, result); end
    checks++;
    if (win1 !== 1'b0 || win2 !== 1'b0)
      begin failures++; $display("FAIL reset_win got=%b%b exp=00", win1, win2); end
    reset = 1'b0;
    n = 0; nw = 0; bad = 0;
    while (busy === 1'b1 && n < 400) begin
      if (mem_we === 1'b1) begin
        if (mem_addr !== 9'(nw) || mem_wdata !== 3'(nw % 5)) bad++;
        nw++;
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 301) begin failures++; $display("FAIL init_busy_cycles got=%0d exp=301", n); end
    checks++;
    if (nw != 300 || bad != 0) begin failures++; $display("FAIL init_writes got=%0d bad=%0d exp=300 bad=0", nw, bad); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL init_done busy=%b exp=0", busy); end
    model_reset(1);
  endtask

  task automatic test_brick();
    int n; bit got; logic [1:0] r; logic we; logic [8:0] ma; logic [2:0] wd;
    poke(21, 3'd2);
    @(negedge clk);
    req1 = 1'b1; addr1 = 9'd21; n = 0; got = 0; r = '0; we = 0; ma = '0; wd = '0;
    while (!got && n < 10) begin
      @(negedge clk); n++;
      if (ack1) begin got = 1; r = result; we = mem_we; ma = mem_addr; wd = mem_wdata; end
    end
    req1 = 1'b0;
    checks++;
    if (!got || n != 2) begin failures++; $display("FAIL brick_latency got=%0d exp=2", n); end
    checks++;
    if (r !== 2'd1) begin failures++; $display("FAIL brick_result got=%0d exp=1", r); end
    checks++;
    if (we !== 1'b1 || ma !== 9'd21 || wd !== 3'd0)
      begin failures++; $display("FAIL brick_write we=%b addr=%0d data=%0d exp 1 21 0", we, ma, wd); end
    @(negedge clk);
    checks++;
    if (win1 !== 1'b0 || win2 !== 1'b0) begin failures++; $display("FAIL brick_win got=%b%b exp=00", win1, win2); end
    checks++;
    if (ram[21] !== 3'd0) begin failures++; $display("FAIL brick_ram got=%0d exp=0", ram[21]); end
  endtask

  task automatic test_tie();
    int c1, c2; logic [1:0] r1v, r2v;
    @(negedge clk);
    req1 = 1'b1; addr1 = 9'd40; req2 = 1'b1; addr2 = 9'd41;
    c1 = 0; c2 = 0; r1v = '0; r2v = '0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (ack1 && c1 == 0) begin c1 = n; r1v = result; req1 = 1'b0; end
      if (ack2 && c2 == 0) begin c2 = n; r2v = result; req2 = 1'b0; end
    end
    req1 = 1'b0; req2 = 1'b0;
    checks++;
    if (c1 != 2) begin failures++; $display("FAIL tie_ack1_cycle got=%0d exp=2", c1); end
    checks++;
    if (c2 != 5) begin failures++; $display("FAIL tie_ack2_cycle got=%0d exp=5", c2); end
    checks++;
    if (r1v !== 2'd0 || r2v !== 2'd3) begin failures++; $display("FAIL tie_results got=%0d,%0d exp=0,3", r1v, r2v); end
    m_last = 2;
  endtask

  task automatic test_base();
    int n; bit got, we_seen; logic [1:0] r; logic w_at_ack;
    @(negedge clk);
    req2 = 1'b1; addr2 = 9'd23; n = 0; got = 0; r = '0; w_at_ack = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk); n++;
      if (ack2) begin got = 1; r = result; w_at_ack = win2; end
    end
    req2 = 1'b0;
    checks++;
    if (!got || n != 2 || r !== 2'd2) begin failures++; $display("FAIL base_hit cyc=%0d res=%0d exp 2 2", n, r); end
    @(negedge clk);
    checks++;
    if (w_at_ack !== 1'b0 || win2 !== 1'b1 || win1 !== 1'b0)
      begin failures++; $display("FAIL base_win at_ack=%b then=%b%b exp 0 then 01", w_at_ack, win1, win2); end
    req1 = 1'b1; addr1 = 9'd22; n = 0; got = 0; we_seen = 0;
    while (!got && n < 10) begin
      @(negedge clk); n++;
      if (mem_we) we_seen = 1;
      if (ack1) begin got = 1; r = result; end
    end
    req1 = 1'b0;
    checks++;
    if (!got || r !== 2'd0 || we_seen) begin failures++; $display("FAIL frozen_hit res=%0d we=%b exp 0 0", r, we_seen); end
    checks++;
    if (ram[22] !== 3'd2) begin failures++; $display("FAIL frozen_ram got=%0d exp=2", ram[22]); end
  endtask

  task automatic test_oob();
    int n; bit got, we_seen; logic [1:0] r;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 0) begin req1 = 1'b1; addr1 = 9'd300; end
      else begin req2 = 1'b1; addr2 = 9'd511; end
      n = 0; got = 0; we_seen = 0; r = '0;
      while (!got && n < 10) begin
        @(negedge clk); n++;
        if (mem_we) we_seen = 1;
        if ((i == 0 && ack1) || (i == 1 && ack2)) begin got = 1; r = result; end
      end
      req1 = 1'b0; req2 = 1'b0;
      @(negedge clk);
      if (mem_we) we_seen = 1;
      checks++;
      if (!got || n != 1 || r !== 2'd3 || we_seen)
        begin failures++; $display("FAIL oob_%0d cyc=%0d res=%0d we=%b exp 1 3 0", i, n, r, we_seen); end
    end
  endtask

  task automatic test_init_pending();
    int n, bad; bit got; logic [1:0] r;
    @(negedge clk);
    req1 = 1'b1; addr1 = 9'd24; n = 0; got = 0;
    while (!got && n < 10) begin @(negedge clk); n++; if (ack1) got = 1; end
    req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (win1 !== 1'b1) begin failures++; $display("FAIL pend_setup win1=%b exp=1", win1); end
    req2 = 1'b1; addr2 = 9'd32;
    @(negedge clk);
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    got = ack2; r = result;
    req2 = 1'b0;
    checks++;
    if (got !== 1'b1 || r !== 2'd0) begin failures++; $display("FAIL pend_ack2 ack=%b res=%0d exp 1 0", got, r); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL pend_idle busy=%b exp=0", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || win1 !== 1'b0 || win2 !== 1'b0)
      begin failures++; $display("FAIL pend_init_entry busy=%b win=%b%b exp 1 00", busy, win1, win2); end
    n = 0;
    while (busy && n < 400) begin
      n++;
      init_start = (n == 100);
      @(negedge clk);
    end
    init_start = 1'b0;
    checks++;
    if (n != 301) begin failures++; $display("FAIL pend_init_len got=%0d exp=301", n); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL init_start_in_init busy=%b exp=0", busy); end
    bad = 0;
    for (int k = 0; k < 300; k++) if (ram[k] !== 3'(k % 5)) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL reload_map bad_cells=%0d exp=0", bad); end
    model_reset(0);
  endtask

  task automatic test_reset_mid();
    bit acked;
    @(negedge clk);
    req1 = 1'b1; addr1 = 9'd22;
    @(negedge clk);
    reset = 1'b1;
    acked = 0;
    repeat (2) begin @(negedge clk); if (ack1 || ack2 || mem_we) acked = 1; end
    req1 = 1'b0;
    checks++;
    if (acked || busy !== 1'b1) begin failures++; $display("FAIL reset_mid ack_or_we=%b busy=%b exp 0 1", acked, busy); end
    reset = 1'b0;
    reset_and_init();
    checks++;
    if (ram[22] !== 3'd2) begin failures++; $display("FAIL reset_mid_ram got=%0d exp=2", ram[22]); end
  endtask

  task automatic test_random();
    int mode, a1, a2, fa, sa, nexp, nacks, cyc, who, res, bad;
    int order [2];
    int ecyc [2];
    bit r1, r2, wr;
    for (int it = 0; it < 60; it++) begin
      if (it % 15 == 0) reset_and_init();
      @(negedge clk);
      checks++;
      if (win1 !== m_win1 || win2 !== m_win2)
        begin failures++; $display("FAIL rand_win it=%0d got=%b%b exp=%b%b", it, win1, win2, m_win1, m_win2); end
      mode = $urandom_range(0, 2);
      a1 = ($urandom_range(0, 9) == 0) ? $urandom_range(300, 511) : $urandom_range(0, 299);
      a2 = ($urandom_range(0, 9) == 0) ? $urandom_range(300, 511) : $urandom_range(0, 299);
      r1 = (mode != 1);
      r2 = (mode != 0);
      if (r1 && r2) order[0] = (m_last == 2) ? 1 : 2;
      else order[0] = r1 ? 1 : 2;
      order[1] = (r1 && r2) ? 3 - order[0] : 0;
      fa = (order[0] == 1) ? a1 : a2;
      sa = (order[1] == 1) ? a1 : a2;
      nexp = (order[1] != 0) ? 2 : 1;
      ecyc[0] = lat(fa);
      ecyc[1] = ecyc[0] + 1 + lat(sa);
      req1 = r1; addr1 = 9'(a1); req2 = r2; addr2 = 9'(a2);
      nacks = 0; cyc = 0;
      while (nacks < nexp && cyc < 20) begin
        @(negedge clk); cyc++;
        if (ack1 || ack2) begin
          who = ack1 ? 1 : 2;
          predict(order[nacks], (nacks == 0) ? fa : sa, res, wr);
          m_last = order[nacks];
          checks++;
          if ((ack1 && ack2) || who != order[nacks] || cyc != ecyc[nacks] || result !== 2'(res) || mem_we !== wr)
            begin
              failures++;
              $display("FAIL rand_txn it=%0d who=%0d cyc=%0d res=%0d we=%b exp who=%0d cyc=%0d res=%0d we=%b",
                       it, who, cyc, result, mem_we, order[nacks], ecyc[nacks], res, wr);
            end
          if (who == 1) req1 = 1'b0; else req2 = 1'b0;
          nacks++;
        end
      end
      req1 = 1'b0; req2 = 1'b0;
      checks++;
      if (nacks != nexp) begin failures++; $display("FAIL rand_timeout it=%0d acks=%0d exp=%0d", it, nacks, nexp); end
    end
    @(negedge clk);
    bad = 0;
    for (int k = 0; k < 300; k++) if (ram[k] !== 3'(m_map[k])) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rand_map bad_cells=%0d exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_brick();
    reset_and_init();
    test_tie();
    test_base();
    reset_and_init();
    test_oob();
    test_init_pending();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
